// File: rtl/coproc_op_ctrl_pkg.sv
// Shared encodings for the coprocessor operation controller.
// The FSM state codes and the status codes reported to the host.
package coproc_op_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_ABORT   = 2'b10,
        ST_ILLEGAL = 2'b11
    } status_e;

endpackage

// File: rtl/coproc_op_ctrl_if.sv
// Host/datapath handshake bundle for coproc_op_ctrl.
// The master drives requests and exec_done; the slave is the controller.
interface coproc_op_ctrl_if #(
    parameter int OP_W  = 3,
    parameter int CNT_W = 8
);
    logic             start;
    logic [OP_W-1:0]  opcode;
    logic             abort;
    logic             exec_done;
    logic             ready;
    logic             busy;
    logic             exec_load;
    logic             exec_en;
    logic [OP_W-1:0]  exec_op;
    logic             done_pulse;
    logic             error;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, opcode, abort, exec_done,
        input  ready, busy, exec_load, exec_en, exec_op,
               done_pulse, error, status, cycle_count
    );

    modport slave (
        input  start, opcode, abort, exec_done,
        output ready, busy, exec_load, exec_en, exec_op,
               done_pulse, error, status, cycle_count
    );
endinterface

// File: rtl/coproc_run_timer.sv
// RUN-phase cycle counter with synchronous clear and terminal-count flag.
// o_tc flags the last RUN cycle allowed before the watchdog fires.
module coproc_run_timer #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_MAX = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_MAX - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TC_VAL);
endmodule

// File: rtl/coproc_op_ctrl.sv
// Start/done run controller: IDLE -> LOAD -> RUN -> FINISH/ERROR with abort,
// illegal-opcode rejection and a RUN-cycle watchdog.
module coproc_op_ctrl
    import coproc_op_ctrl_pkg::*;
#(
    parameter int OP_W        = 3,
    parameter int NUM_OPS     = 6,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_MAX = 200
) (
    input logic             clk,
    input logic             reset,
    coproc_op_ctrl_if.slave bus
);
    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [OP_W-1:0] r_exec_op;
    status_e         r_status;
    logic            w_op_legal;
    logic            w_tc;
    logic [CNT_W-1:0] w_count;

    assign w_op_legal = ({{(32-OP_W){1'b0}}, bus.opcode} < NUM_OPS);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = w_op_legal ? S_LOAD : S_ERROR;
            S_LOAD:   w_next = bus.abort ? S_ERROR : S_RUN;
            S_RUN: begin
                if (bus.abort)          w_next = S_ERROR;
                else if (bus.exec_done) w_next = S_FINISH;
                else if (w_tc)          w_next = S_ERROR;
            end
            S_FINISH: w_next = S_IDLE;
            S_ERROR:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Status follows the same priority as the RUN exit decode above.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_exec_op <= '0;
            r_status  <= ST_OK;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start) begin
                r_exec_op <= bus.opcode;
                if (!w_op_legal) r_status <= ST_ILLEGAL;
            end
            if (r_state == S_LOAD && bus.abort)
                r_status <= ST_ABORT;
            if (r_state == S_RUN) begin
                if (bus.abort)          r_status <= ST_ABORT;
                else if (bus.exec_done) r_status <= ST_OK;
                else if (w_tc)          r_status <= ST_TIMEOUT;
            end
        end
    end

    coproc_run_timer #(
        .CNT_W       (CNT_W),
        .TIMEOUT_MAX (TIMEOUT_MAX)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (r_state == S_LOAD),
        .i_en    (r_state == S_RUN),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    assign bus.ready       = (r_state == S_IDLE);
    assign bus.busy        = (r_state == S_LOAD) || (r_state == S_RUN);
    assign bus.exec_load   = (r_state == S_LOAD);
    assign bus.exec_en     = (r_state == S_RUN);
    assign bus.done_pulse  = (r_state == S_FINISH) || (r_state == S_ERROR);
    assign bus.error       = (r_state == S_ERROR);
    assign bus.exec_op     = r_exec_op;
    assign bus.status      = r_status;
    assign bus.cycle_count = w_count;
endmodule

// File: tb/tb_coproc_op_ctrl.sv
// Self-checking bench for coproc_op_ctrl: directed cases plus randomized
// operations scored against a per-operation outcome model.
module tb_coproc_op_ctrl;
    localparam int OP_W = 3, NUM_OPS = 6, CNT_W = 8, TMAX = 200;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    int   prev_cc = 0;

    coproc_op_ctrl_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus ();

    coproc_op_ctrl #(
        .OP_W(OP_W), .NUM_OPS(NUM_OPS), .CNT_W(CNT_W), .TIMEOUT_MAX(TMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation: abort_at -1 = never, 0 = in LOAD, k = RUN cycle k;
    // done_at 0 = never, k = RUN cycle k.
    task automatic run_op(input int op, input int abort_at, input int done_at);
        int e_status, e_runs, e_loads, e_cc, e;
        int runs, loads, ridx;
        logic [31:0] opv;
        bit seen;
        opv = op;
        if (op >= NUM_OPS) begin
            e_status = 3; e_runs = 0; e_loads = 0; e_cc = prev_cc;
        end else if (abort_at == 0) begin
            e_status = 2; e_runs = 0; e_loads = 1; e_cc = 0;
        end else begin
            e = TMAX;
            if (done_at >= 1 && done_at < e) e = done_at;
            if (abort_at >= 1 && abort_at <= e) e = abort_at;
            e_status = (abort_at == e) ? 2 : (done_at == e) ? 0 : 1;
            e_runs = e; e_loads = 1; e_cc = e;
        end
        prev_cc = e_cc;

        @(negedge clk);
        check("ready_before_start", bus.ready, 1);
        bus.start = 1'b1; bus.opcode = opv[OP_W-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        runs = 0; loads = 0; ridx = 0; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            bus.abort = 1'b0; bus.exec_done = 1'b0;
            if (bus.done_pulse) seen = 1;
            else begin
                if (bus.exec_load) begin
                    loads++;
                    if (abort_at == 0) bus.abort = 1'b1;
                end
                if (bus.exec_en) begin
                    runs++; ridx++;
                    bus.abort     = (ridx == abort_at);
                    bus.exec_done = (ridx == done_at);
                end
                @(negedge clk);
            end
        end
        bus.abort = 1'b0; bus.exec_done = 1'b0;
        check("op_terminated", seen, 1);
        if (seen) begin
            check("status", bus.status, e_status);
            check("cycle_count", bus.cycle_count, e_cc);
            check("error", bus.error, (e_status != 0));
            check("exec_op", bus.exec_op, opv[OP_W-1:0]);
            check("run_cycles", runs, e_runs);
            check("load_cycles", loads, e_loads);
            check("ready_in_done", bus.ready, 0);
            @(negedge clk);
            check("done_single_pulse", bus.done_pulse, 0);
            check("ready_after_done", bus.ready, 1);
            check("status_held", bus.status, e_status);
        end
    endtask

    initial begin
        int a, d, r;
        bit seen;
        bus.start = 1'b0; bus.opcode = '0; bus.abort = 1'b0; bus.exec_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done_pulse, 0);
        check("rst_status", bus.status, 0);
        check("rst_cc", bus.cycle_count, 0);
        check("rst_exec_op", bus.exec_op, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.ready, 1);
        check("idle_exec_en", bus.exec_en, 0);

        run_op(2, -1, 5);      // normal
        run_op(7, -1, 0);      // illegal opcode
        run_op(6, -1, 3);      // first illegal code
        run_op(1, -1, 0);      // timeout
        run_op(3, 0, 0);       // abort in LOAD
        run_op(4, 3, 3);       // abort + done together
        run_op(0, -1, 1);      // minimum latency
        run_op(5, 201, 200);   // done on the timeout cycle wins

        // Reset in RUN cycle 4 aborts without a done pulse.
        run_op(1, -1, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = 3'd2;
        @(negedge clk); bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_run_en", bus.exec_en, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", bus.ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done_pulse, 0);
        check("mid_rst_status", bus.status, 0);
        check("mid_rst_cc", bus.cycle_count, 0);
        check("mid_rst_exec_op", bus.exec_op, 0);
        @(negedge clk);
        check("mid_rst_no_done", bus.done_pulse, 0);
        reset = 1'b1; prev_cc = 0;

        // Back-to-back with start held high.
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = 3'd4;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            bus.exec_done = bus.exec_en;
            if (bus.done_pulse) seen = 1;
        end
        check("b2b_first_done", seen, 1);
        check("b2b_first_cc", bus.cycle_count, 1);
        bus.exec_done = 1'b0; bus.opcode = 3'd5;
        @(negedge clk);
        check("b2b_idle_ready", bus.ready, 1);
        @(negedge clk);
        check("b2b_reaccept_load", bus.exec_load, 1);
        check("b2b_exec_op", bus.exec_op, 5);
        bus.start = 1'b0;
        @(negedge clk);
        bus.exec_done = 1'b1;
        @(negedge clk);
        bus.exec_done = 1'b0;
        check("b2b_second_done", bus.done_pulse, 1);
        check("b2b_second_status", bus.status, 0);
        prev_cc = 1;

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            a = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(1, 25)) : -1;
            d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 25));
            run_op(int'($urandom_range(0, 7)), a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/coproc_op_ctrl.md
Name: coproc_op_ctrl

Overview:
Parametrised successor to the coprocessor's start/done run controller. Accepts an opcode with a start request and sequences IDLE -> LOAD -> RUN -> FINISH/ERROR. Drives the datapath's load/enable strobes, times each operation with a timeout watchdog, and supports abort. Reports completion status and RUN cycle count to the host interface. Sits between the host register block and the coprocessor datapath.

Parameters:
OP_W, 3, opcode width in bits.
NUM_OPS, 6, number of legal opcodes; legal range is 0..NUM_OPS-1 (NUM_OPS <= 2^OP_W).
CNT_W, 8, width of the RUN cycle counter.
TIMEOUT_MAX, 200, maximum RUN cycles before timeout; 1 <= TIMEOUT_MAX <= 2^CNT_W-1.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; asserted when 0.
start  input  1  operation request; sampled only while ready=1.
opcode  input  OP_W  operation code; sampled on the start-accept edge.
abort  input  1  host abort request.
exec_done  input  1  datapath completion indication.
ready  output  1  high only in IDLE.
busy  output  1  high in LOAD and RUN.
exec_load  output  1  high for exactly the one LOAD cycle.
exec_en  output  1  high throughout RUN.
exec_op  output  OP_W  latched opcode; stable from LOAD until the next accept.
done_pulse  output  1  one-cycle pulse in FINISH or ERROR.
error  output  1  high in ERROR only.
status  output  2  00 ok, 01 timeout, 10 aborted, 11 illegal opcode; held until the next accept.
cycle_count  output  CNT_W  RUN cycles used by the last operation; held until the next LOAD.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - exec_op=0, status=00, cycle_count=0.
  - All strobes low; ready=1.
- Output decoding:
  - Strobes (ready, busy, exec_load, exec_en, done_pulse, error) are Moore outputs decoded from state.
  - exec_op, status and cycle_count are registers.
- States use a 3-bit encoding: IDLE, LOAD, RUN, FINISH, ERROR. Any unused encoding returns to IDLE on the next edge.
- IDLE:
  - start=1 with opcode < NUM_OPS: latch exec_op, go to LOAD.
  - start=1 with opcode >= NUM_OPS: latch exec_op, go to ERROR, status<=11.
  - abort and exec_done are ignored.
- LOAD:
  - Lasts one cycle; cycle_count<=0.
  - abort=1: go to ERROR, status<=10.
  - Otherwise: go to RUN.
- RUN: cycle_count<=cycle_count+1 every RUN cycle. Exit priority, highest first:
  - abort=1: go to ERROR, status<=10.
  - exec_done=1: go to FINISH, status<=00.
  - cycle_count==TIMEOUT_MAX-1: go to ERROR, status<=01.
  - Otherwise: stay in RUN.
- Simultaneous abort and exec_done in RUN: abort wins.
- FINISH: done_pulse=1 for one cycle, then IDLE.
- ERROR: done_pulse=1 and error=1 for one cycle, then IDLE.
- Latency:
  - Start accepted on edge k gives LOAD in cycle k+1 and RUN from k+2.
  - exec_done in the n-th RUN cycle gives cycle_count=n and done_pulse in the next cycle.
  - Minimum start to done_pulse is 3 cycles.
- Timeout: RUN lasts at most TIMEOUT_MAX cycles; on timeout cycle_count=TIMEOUT_MAX.
- Back-to-back operation: start held high re-accepts in the first IDLE cycle after FINISH/ERROR. ready is low during FINISH/ERROR.
- A reset asserted mid-operation aborts immediately, with no done_pulse.

Decomposition:
- Shared package: state encodings (IDLE..ERROR) and status codes (ST_OK, ST_TIMEOUT, ST_ABORT, ST_ILLEGAL).
- One natural sub-module: coproc_run_timer. It holds the counter with clear, enable and terminal-count compare against TIMEOUT_MAX-1.
- The FSM itself stays in the top module.

Test Plan:
- Reset/idle: reset=0 then release -> ready=1, busy=0, status=00, cycle_count=0, exec_op=0.
- Normal op: start=1, opcode=2; exec_done in the 5th RUN cycle -> exec_load pulses once, exec_en high 5 cycles, done_pulse 1 cycle, status=00, cycle_count=5, exec_op=2.
- Illegal opcode: start=1, opcode=7 (NUM_OPS=6) -> no LOAD/RUN, next cycle error=1 and done_pulse=1, status=11.
- Timeout: start, exec_done never asserted -> exactly 200 RUN cycles, then ERROR, status=01, cycle_count=200.
- Abort:
  - abort in LOAD -> ERROR with status=10, no RUN cycle.
  - abort and exec_done together in RUN cycle 3 -> status=10, cycle_count=3.
- Reset mid-RUN and back-to-back:
  - reset=0 in RUN cycle 4 -> immediate IDLE, no done_pulse.
  - start held high -> second op accepted in the cycle after done_pulse.
